// File: rtl/lcd_responder.sv
// HD44780-style LCD bus responder: decodes bus writes into a 32-byte DDRAM mirror and answers busy/data reads.
// Latency: a write takes effect (and oCMD_STB pulses) 3 clocks after the pin-level LCD_E fall; oRD_CHAR lags iRD_ADDR by 1 clock.
// Backpressure: oBUSY is the only flow control; a write arriving while busy is dropped and latched on oERR.

module lcd_responder #(
  parameter int BUSY_CYCLES  = 2000,
  parameter int CLEAR_CYCLES = 82000
) (
  input  logic       iCLK_50MHZ,
  input  logic       iRST_N,
  input  logic       LCD_E,
  input  logic       LCD_RS,
  input  logic       LCD_RW,
  inout  wire  [7:0] DATA_BUS,
  input  logic [4:0] iRD_ADDR,
  output logic [7:0] oRD_CHAR,
  output logic       oBUSY,
  output logic [6:0] oAC,
  output logic       oDISP_ON,
  output logic       oCMD_STB,
  output logic       oERR
);

  localparam int MAX_CYCLES = (BUSY_CYCLES > CLEAR_CYCLES) ? BUSY_CYCLES : CLEAR_CYCLES;
  localparam int CW         = (MAX_CYCLES < 2) ? 1 : $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] BUSY_LOAD  = CW'(BUSY_CYCLES);
  localparam logic [CW-1:0] CLEAR_LOAD = CW'(CLEAR_CYCLES);
  localparam logic [7:0]    BLANK      = 8'h20;

  typedef enum logic {
    ST_FILL,
    ST_RUN
  } state_e;

  // Address-counter stepping that hops between the two visible 16-char lines.
  function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic inc);
    logic [6:0] nxt;
    if (inc) begin
      case (ac)
        7'h0F:   nxt = 7'h40;
        7'h4F:   nxt = 7'h00;
        default: nxt = ac + 7'd1;
      endcase
    end else begin
      case (ac)
        7'h00:   nxt = 7'h4F;
        7'h40:   nxt = 7'h0F;
        default: nxt = ac - 7'd1;
      endcase
    end
    return nxt;
  endfunction

  // Synchronizer stages and the previous-cycle copy used for edge detection.
  logic       e_s1_q, e_s2_q, e_p_q;
  logic       rs_s1_q, rs_s2_q, rs_p_q;
  logic       rw_s1_q, rw_s2_q, rw_p_q;
  logic [7:0] dat_s1_q, dat_s2_q, dat_p_q;

  // Control state.
  state_e          state_q;
  logic [5:0]      fill_idx_q;
  logic [6:0]      ac_q, ac_d;
  logic            id_q, id_d;
  logic            disp_q, disp_d;
  logic            err_q, err_d;
  logic            stb_q, stb_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      rd_q, rd_d;
  logic [7:0]      rd_char_q;
  logic [7:0]      ddram_q [32];

  // Decode helpers.
  logic       fall, wr_ev, rd_ev, busy, wr_acc, cmd_acc, dat_acc, clr_acc;
  logic       ac_map, fill_we;
  logic [4:0] ac_idx;

  // Bring every bus pin into the clock domain and keep one cycle of history.
  always_ff @(posedge iCLK_50MHZ or negedge iRST_N) begin
    if (!iRST_N) begin
      e_s1_q   <= 1'b0;
      e_s2_q   <= 1'b0;
      e_p_q    <= 1'b0;
      rs_s1_q  <= 1'b0;
      rs_s2_q  <= 1'b0;
      rs_p_q   <= 1'b0;
      rw_s1_q  <= 1'b0;
      rw_s2_q  <= 1'b0;
      rw_p_q   <= 1'b0;
      dat_s1_q <= '0;
      dat_s2_q <= '0;
      dat_p_q  <= '0;
    end else begin
      e_s1_q   <= LCD_E;
      e_s2_q   <= e_s1_q;
      e_p_q    <= e_s2_q;
      rs_s1_q  <= LCD_RS;
      rs_s2_q  <= rs_s1_q;
      rs_p_q   <= rs_s2_q;
      rw_s1_q  <= LCD_RW;
      rw_s2_q  <= rw_s1_q;
      rw_p_q   <= rw_s2_q;
      dat_s1_q <= DATA_BUS;
      dat_s2_q <= dat_s1_q;
      dat_p_q  <= dat_s2_q;
    end
  end

  // A bus transaction completes on the synchronized E fall; RS/RW/data come from the cycle before it.
  always_comb begin
    fall    = e_p_q & ~e_s2_q;
    wr_ev   = fall & ~rw_p_q;
    rd_ev   = fall & rw_p_q & rs_p_q;
    busy    = (cnt_q != '0) || (state_q == ST_FILL);
    wr_acc  = wr_ev & ~busy;
    cmd_acc = wr_acc & ~rs_p_q;
    dat_acc = wr_acc & rs_p_q;
    clr_acc = cmd_acc && (dat_p_q == 8'h01);
    ac_map  = (ac_q[6:4] == 3'b000) || (ac_q[6:4] == 3'b100);
    ac_idx  = {ac_q[6], ac_q[3:0]};
    fill_we = (state_q == ST_FILL) && !fill_idx_q[5];
  end

  // Blank-fill sequencer: after reset or a clear, walks all 32 entries before normal operation resumes.
  always_ff @(posedge iCLK_50MHZ or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q    <= ST_FILL;
      fill_idx_q <= '0;
    end else begin
      case (state_q)
        ST_FILL: begin
          if (fill_idx_q[5]) state_q <= ST_RUN;
          else fill_idx_q <= fill_idx_q + 6'd1;
        end
        ST_RUN: begin
          if (clr_acc) begin
            state_q    <= ST_FILL;
            fill_idx_q <= '0;
          end
        end
        default: state_q <= ST_FILL;
      endcase
    end
  end

  // Command / data-write decoder, read-side AC stepping, busy countdown and the sticky error flag.
  always_comb begin
    ac_d   = ac_q;
    id_d   = id_q;
    disp_d = disp_q;
    err_d  = err_q | (wr_ev & busy);
    stb_d  = wr_acc;
    cnt_d  = cnt_q;
    if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
    if (dat_acc) begin
      ac_d  = ac_step(ac_q, id_q);
      cnt_d = BUSY_LOAD;
    end else if (cmd_acc) begin
      cnt_d = BUSY_LOAD;
      casez (dat_p_q)
        8'b1???????: ac_d = dat_p_q[6:0];
        8'b01??????, 8'b001?????: begin
          // CGRAM address and function set have no visible effect here.
        end
        8'b0001????: begin
          // Only cursor moves affect the mirror; display shifts are ignored.
          if (!dat_p_q[3]) ac_d = ac_step(ac_q, dat_p_q[2]);
        end
        8'b00001???: disp_d = dat_p_q[2];
        8'b000001??: id_d = dat_p_q[1];
        8'b0000001?: begin
          ac_d  = 7'h00;
          cnt_d = CLEAR_LOAD;
        end
        8'b00000001: begin
          ac_d  = 7'h00;
          id_d  = 1'b1;
          cnt_d = CLEAR_LOAD;
        end
        default: begin
          // 0x00 is not a command; it only occupies the bus for the normal busy time.
        end
      endcase
    end else if (rd_ev) begin
      ac_d = ac_step(ac_q, id_q);
    end
  end

  // Read register tracks the status word or the DDRAM byte under AC every clock.
  always_comb begin
    rd_d = {busy, ac_q};
    if (rs_s2_q) rd_d = ac_map ? ddram_q[ac_idx] : BLANK;
  end

  // Control and output registers.
  always_ff @(posedge iCLK_50MHZ or negedge iRST_N) begin
    if (!iRST_N) begin
      ac_q      <= 7'h00;
      id_q      <= 1'b1;
      disp_q    <= 1'b0;
      err_q     <= 1'b0;
      stb_q     <= 1'b0;
      cnt_q     <= '0;
      rd_q      <= '0;
      rd_char_q <= BLANK;
    end else begin
      ac_q      <= ac_d;
      id_q      <= id_d;
      disp_q    <= disp_d;
      err_q     <= err_d;
      stb_q     <= stb_d;
      cnt_q     <= cnt_d;
      rd_q      <= rd_d;
      rd_char_q <= ddram_q[iRD_ADDR];
    end
  end

  // DDRAM storage: the fill sequencer owns the array while active, otherwise accepted data writes to mapped AC.
  always_ff @(posedge iCLK_50MHZ) begin
    if (fill_we) ddram_q[fill_idx_q[4:0]] <= BLANK;
    else if (dat_acc && ac_map) ddram_q[ac_idx] <= dat_p_q;
  end

  // Drive the bus straight from the raw pins so the host sees data as soon as it strobes a read.
  assign DATA_BUS = (LCD_E && LCD_RW) ? rd_q : 8'hzz;

  assign oRD_CHAR = rd_char_q;
  assign oBUSY    = busy;
  assign oAC      = ac_q;
  assign oDISP_ON = disp_q;
  assign oCMD_STB = stb_q;
  assign oERR     = err_q;

endmodule

// File: tb/tb_lcd_responder.sv
// Testbench for lcd_responder: random bus traffic against a DDRAM/AC reference model.
// Latency: bus cycles take ~6 clocks; every write waits for oBUSY to clear before the next one.
// Backpressure: writes during busy are issued on purpose in one scenario to exercise oERR.

module tb_lcd_responder;

  localparam int BUSY = 8;
  localparam int CLR  = 100;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       lcd_e = 1'b0;
  logic       lcd_rs = 1'b0;
  logic       lcd_rw = 1'b0;
  logic [4:0] rd_addr = 5'd0;
  logic       drv_en = 1'b0;
  logic [7:0] drv_dat = 8'h00;
  wire  [7:0] data_bus;
  logic [7:0] rd_char;
  logic       busy, disp, stb, err;
  logic [6:0] ac;

  assign data_bus = drv_en ? drv_dat : 8'hzz;

  lcd_responder #(.BUSY_CYCLES(BUSY), .CLEAR_CYCLES(CLR)) dut (
    .iCLK_50MHZ(clk),
    .iRST_N    (rst_n),
    .LCD_E     (lcd_e),
    .LCD_RS    (lcd_rs),
    .LCD_RW    (lcd_rw),
    .DATA_BUS  (data_bus),
    .iRD_ADDR  (rd_addr),
    .oRD_CHAR  (rd_char),
    .oBUSY     (busy),
    .oAC       (ac),
    .oDISP_ON  (disp),
    .oCMD_STB  (stb),
    .oERR      (err)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int stb_cnt = 0;
  bit idle_ok = 1'b1;

  always @(negedge clk) if (stb === 1'b1) stb_cnt++;

  // Reference model: display memory as 32 linear positions, AC as an address.
  logic [7:0] m_mem [32];
  logic [6:0] m_ac;
  logic       m_id, m_disp;
  logic [7:0] obs_mem [32];

  function automatic bit m_valid(input logic [6:0] a);
    return (a < 7'h10) || (a >= 7'h40 && a < 7'h50);
  endfunction

  function automatic int m_pos(input logic [6:0] a);
    return (a >= 7'h40) ? int'(a) - 64 + 16 : int'(a);
  endfunction

  function automatic logic [6:0] m_from_pos(input int p);
    return (p < 16) ? 7'(p) : 7'(p - 16 + 64);
  endfunction

  function automatic logic [6:0] m_step(input logic [6:0] a, input logic inc);
    if (m_valid(a)) return m_from_pos(inc ? (m_pos(a) + 1) % 32 : (m_pos(a) + 31) % 32);
    return inc ? 7'(int'(a) + 1) : 7'(int'(a) + 127);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 32; i++) m_mem[i] = 8'h20;
    m_ac = 7'h00;
    m_id = 1'b1;
    m_disp = 1'b0;
  endtask

  task automatic model_cmd(input logic [7:0] c);
    if (c >= 8'h80) m_ac = c[6:0];
    else if (c >= 8'h20) m_ac = m_ac;
    else if (c >= 8'h10) begin
      if (!c[3]) m_ac = m_step(m_ac, c[2]);
    end
    else if (c >= 8'h08) m_disp = c[2];
    else if (c >= 8'h04) m_id = c[1];
    else if (c >= 8'h02) m_ac = 7'h00;
    else if (c == 8'h01) begin
      for (int i = 0; i < 32; i++) m_mem[i] = 8'h20;
      m_ac = 7'h00;
      m_id = 1'b1;
    end
  endtask

  task automatic model_data(input logic [7:0] d);
    if (m_valid(m_ac)) m_mem[m_pos(m_ac)] = d;
    m_ac = m_step(m_ac, m_id);
  endtask

  // Bus write; returns one clock after the pin-level E fall.
  task automatic bus_write(input logic rs, input logic [7:0] d);
    @(negedge clk);
    lcd_rs = rs; lcd_rw = 1'b0; drv_dat = d; drv_en = 1'b1;
    @(negedge clk);
    lcd_e = 1'b1;
    repeat (3) @(negedge clk);
    lcd_e = 1'b0;
    @(negedge clk);
    drv_en = 1'b0;
  endtask

  task automatic bus_read(input logic rs, output logic [7:0] v);
    @(negedge clk);
    lcd_rs = rs; lcd_rw = 1'b1; drv_en = 1'b0;
    @(negedge clk);
    lcd_e = 1'b1;
    repeat (4) @(negedge clk);
    v = data_bus;
    lcd_e = 1'b0;
    repeat (4) @(negedge clk);
    lcd_rw = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 400 && !ok; i++) begin
      if (busy === 1'b0) ok = 1'b1;
      else @(negedge clk);
    end
  endtask

  task automatic do_write(input logic rs, input logic [7:0] d);
    bit ok;
    bus_write(rs, d);
    if (rs) model_data(d);
    else model_cmd(d);
    wait_idle(ok);
    if (!ok) idle_ok = 1'b0;
  endtask

  task automatic dump_mem();
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      rd_addr = 5'(i);
      @(negedge clk);
      obs_mem[i] = rd_char;
    end
  endtask

  task automatic test_reset();
    int hi;
    bit done;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rst_busy got %b exp 1", busy); end
    checks++; if (ac !== 7'h00) begin failures++; $display("FAIL rst_ac got %h exp 00", ac); end
    checks++; if (disp !== 1'b0) begin failures++; $display("FAIL rst_disp got %b exp 0", disp); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL rst_err got %b exp 0", err); end
    checks++; if (stb !== 1'b0) begin failures++; $display("FAIL rst_stb got %b exp 0", stb); end
    checks++; if (rd_char !== 8'h20) begin failures++; $display("FAIL rst_rdchar got %h exp 20", rd_char); end
    rst_n = 1'b1;
    m_reset();
    hi = 0; done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (busy === 1'b1) hi++;
      else done = 1'b1;
    end
    checks++;
    if (!done || hi < 32 || hi > 34) begin failures++; $display("FAIL init_busy_len got %0d exp 32..34", hi); end
    dump_mem();
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (obs_mem[i] !== 8'h20) begin failures++; $display("FAIL init_mem[%0d] got %h exp 20", i, obs_mem[i]); end
    end
  endtask

  task automatic test_write_timing();
    logic [7:0] cmds [2];
    logic       rss [2];
    logic [11:0] stb_tr, busy_tr;
    int base;
    bit ok;
    cmds[0] = 8'h80; rss[0] = 1'b0;
    cmds[1] = 8'h41; rss[1] = 1'b1;
    base = stb_cnt;
    for (int k = 0; k < 2; k++) begin
      stb_tr = '0; busy_tr = '0;
      bus_write(rss[k], cmds[k]);
      for (int j = 1; j <= 11; j++) begin
        if (j > 1) @(negedge clk);
        stb_tr[j] = stb;
        busy_tr[j] = busy;
      end
      if (rss[k]) model_data(cmds[k]); else model_cmd(cmds[k]);
      checks++; if (stb_tr !== 12'h008) begin failures++; $display("FAIL stb_timing[%0d] got %h exp 008", k, stb_tr); end
      checks++; if (busy_tr !== 12'h7F8) begin failures++; $display("FAIL busy_timing[%0d] got %h exp 7f8", k, busy_tr); end
      wait_idle(ok);
      if (!ok) idle_ok = 1'b0;
    end
    checks++; if (stb_cnt - base !== 2) begin failures++; $display("FAIL stb_count got %0d exp 2", stb_cnt - base); end
    checks++; if (ac !== 7'h01) begin failures++; $display("FAIL wr_ac got %h exp 01", ac); end
    @(negedge clk); rd_addr = 5'd0; @(negedge clk);
    checks++; if (rd_char !== 8'h41) begin failures++; $display("FAIL wr_char got %h exp 41", rd_char); end
  endtask

  task automatic test_line_wrap();
    do_write(1'b0, 8'h8F);
    do_write(1'b1, 8'h42);
    do_write(1'b1, 8'h43);
    checks++; if (ac !== 7'h41) begin failures++; $display("FAIL wrap_ac got %h exp 41", ac); end
    @(negedge clk); rd_addr = 5'd15; @(negedge clk);
    checks++; if (rd_char !== 8'h42) begin failures++; $display("FAIL wrap_idx15 got %h exp 42", rd_char); end
    @(negedge clk); rd_addr = 5'd16; @(negedge clk);
    checks++; if (rd_char !== 8'h43) begin failures++; $display("FAIL wrap_idx16 got %h exp 43", rd_char); end
    do_write(1'b0, 8'h04);
    do_write(1'b0, 8'hC0);
    do_write(1'b1, 8'h44);
    checks++; if (ac !== 7'h0F) begin failures++; $display("FAIL dec_ac got %h exp 0f", ac); end
    @(negedge clk); rd_addr = 5'd16; @(negedge clk);
    checks++; if (rd_char !== 8'h44) begin failures++; $display("FAIL dec_idx16 got %h exp 44", rd_char); end
    do_write(1'b0, 8'h06);
  endtask

  task automatic test_status_read();
    logic [7:0] v;
    bit ok;
    bus_write(1'b1, 8'h55);
    model_data(8'h55);
    lcd_rs = 1'b0; lcd_rw = 1'b1;
    @(negedge clk);
    lcd_e = 1'b1;
    repeat (4) @(negedge clk);
    v = data_bus;
    lcd_e = 1'b0;
    repeat (4) @(negedge clk);
    lcd_rw = 1'b0;
    checks++; if (v !== {1'b1, m_ac}) begin failures++; $display("FAIL status_busy got %h exp %h", v, {1'b1, m_ac}); end
    wait_idle(ok);
    if (!ok) idle_ok = 1'b0;
    bus_read(1'b0, v);
    checks++; if (v !== {1'b0, m_ac}) begin failures++; $display("FAIL status_idle got %h exp %h", v, {1'b0, m_ac}); end
  endtask

  task automatic test_random();
    logic [7:0] v, exp_v;
    logic [6:0] a;
    int op;
    for (int it = 0; it < 80; it++) begin
      op = int'($urandom_range(0, 10));
      case (op)
        4: begin
          if ($urandom_range(0, 3) != 0) a = m_from_pos(int'($urandom_range(0, 31)));
          else a = 7'($urandom_range(0, 127));
          do_write(1'b0, {1'b1, a});
        end
        5: do_write(1'b0, 8'h04 | 8'($urandom_range(0, 3)));
        6: do_write(1'b0, 8'h10 | 8'($urandom_range(0, 15)));
        7: do_write(1'b0, 8'h08 | 8'($urandom_range(0, 7)));
        8: begin
          exp_v = m_valid(m_ac) ? m_mem[m_pos(m_ac)] : 8'h20;
          bus_read(1'b1, v);
          m_ac = m_step(m_ac, m_id);
          checks++; if (v !== exp_v) begin failures++; $display("FAIL rnd_dread[%0d] got %h exp %h", it, v, exp_v); end
        end
        9: begin
          bus_read(1'b0, v);
          checks++; if (v !== {1'b0, m_ac}) begin failures++; $display("FAIL rnd_status[%0d] got %h exp %h", it, v, {1'b0, m_ac}); end
        end
        10: do_write(1'b0, 8'($urandom_range(32, 127)));
        default: do_write(1'b1, 8'($urandom_range(33, 126)));
      endcase
      checks++; if (ac !== m_ac) begin failures++; $display("FAIL rnd_ac[%0d] op %0d got %h exp %h", it, op, ac, m_ac); end
      if (it % 20 == 19) begin
        dump_mem();
        for (int i = 0; i < 32; i++) begin
          checks++;
          if (obs_mem[i] !== m_mem[i]) begin failures++; $display("FAIL rnd_mem[%0d] got %h exp %h", i, obs_mem[i], m_mem[i]); end
        end
      end
    end
    checks++; if (disp !== m_disp) begin failures++; $display("FAIL rnd_disp got %b exp %b", disp, m_disp); end
  endtask

  task automatic test_busy_write();
    int base;
    bit ok;
    do_write(1'b0, 8'h06);
    do_write(1'b0, 8'h85);
    base = stb_cnt;
    bus_write(1'b1, 8'h61);
    model_data(8'h61);
    bus_write(1'b1, 8'h62);
    wait_idle(ok);
    if (!ok) idle_ok = 1'b0;
    checks++; if (stb_cnt - base !== 1) begin failures++; $display("FAIL busy_stb got %0d exp 1", stb_cnt - base); end
    checks++; if (ac !== 7'h06) begin failures++; $display("FAIL busy_ac got %h exp 06", ac); end
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL busy_err got %b exp 1", err); end
    dump_mem();
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (obs_mem[i] !== m_mem[i]) begin failures++; $display("FAIL busy_mem[%0d] got %h exp %h", i, obs_mem[i], m_mem[i]); end
    end
    do_write(1'b1, 8'h63);
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL err_sticky got %b exp 1", err); end
    checks++; if (ac !== m_ac) begin failures++; $display("FAIL busy_ac2 got %h exp %h", ac, m_ac); end
  endtask

  task automatic test_reset_mid_clear();
    bit ok;
    do_write(1'b0, 8'h0C);
    do_write(1'b0, 8'hC3);
    bus_write(1'b0, 8'h01);
    repeat (11) @(negedge clk);
    checks++; if (disp !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL pre_rst got disp=%b busy=%b exp 1 1", disp, busy); end
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mid_rst_busy got %b exp 1", busy); end
    checks++; if (ac !== 7'h00) begin failures++; $display("FAIL mid_rst_ac got %h exp 00", ac); end
    checks++; if (disp !== 1'b0) begin failures++; $display("FAIL mid_rst_disp got %b exp 0", disp); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL mid_rst_err got %b exp 0", err); end
    checks++; if (stb !== 1'b0) begin failures++; $display("FAIL mid_rst_stb got %b exp 0", stb); end
    checks++; if (rd_char !== 8'h20) begin failures++; $display("FAIL mid_rst_rdchar got %h exp 20", rd_char); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    m_reset();
    wait_idle(ok);
    checks++; if (!ok) begin failures++; $display("FAIL post_rst_fill got busy=%b exp 0", busy); end
    checks++; if (ac !== m_ac) begin failures++; $display("FAIL post_rst_ac got %h exp %h", ac, m_ac); end
    dump_mem();
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (obs_mem[i] !== 8'h20) begin failures++; $display("FAIL post_rst_mem[%0d] got %h exp 20", i, obs_mem[i]); end
    end
  endtask

  task automatic test_idle_bounds();
    checks++;
    if (!idle_ok) begin failures++; $display("FAIL busy_timeout got stuck busy exp release within bound"); end
  endtask

  initial begin
    test_reset();
    test_write_timing();
    test_line_wrap();
    test_status_read();
    test_random();
    test_busy_write();
    test_reset_mid_clear();
    test_idle_bounds();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got no completion exp finish before 1ms");
    $fatal(1, "watchdog expired");
  end

endmodule
